// File: rtl/aes_bcd_pkg.sv
// Shared types and constants for the sequential BCD-to-binary decoder.
package aes_bcd_pkg;

    // Decoder control states
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned NDIG    = 3;    // BCD digits per input word
    localparam int unsigned ITER    = 10;   // shift iterations, equals binary width (999 < 2^10)
    localparam int unsigned BIN_MAX = 255;  // largest value that fits the 8-bit result

    // A BCD digit is legal when it encodes 0..9
    function automatic logic digit_valid(input logic [3:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: a shifted digit >= 8 has picked up
// a half-ten from the digit above and must be brought back by 3.
module bcd_digit_adj (
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= 4'd8) ? d_i - 4'd3 : d_i;

endmodule

// File: rtl/bcd_decoder_seq.sv
// Sequential 3-digit BCD to binary converter, one reverse double-dabble
// iteration per clock, with valid/ready handshakes on both sides.
module bcd_decoder_seq
    import aes_bcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [4*NDIG-1:0]     bcd_in_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [7:0]            bin_out_o,
    output logic                  ovf_o,
    output logic                  invalid_o
);

    localparam int unsigned BcdW = 4 * NDIG;
    localparam int unsigned CntW = 4;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic [ITER-1:0]     bin_q, bin_d;
    logic [7:0]          bin_out_q, bin_out_d;
    logic                ovf_q, ovf_d;
    logic                invalid_q, invalid_d;

    logic [BcdW+ITER-1:0] shifted;
    logic [BcdW-1:0]      bcd_adj;
    logic                 in_ok;
    logic                 last_iter;

    assign shifted   = {bcd_q, bin_q} >> 1;
    assign last_iter = (cnt_q == CntW'(ITER - 1));

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_i (shifted[ITER + 4*i +: 4]),
            .d_o (bcd_adj[4*i +: 4])
        );
    end

    // Flag any non-decimal digit in the offered word
    always_comb begin
        in_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!digit_valid(bcd_in_i[4*i +: 4])) begin
                in_ok = 1'b0;
            end
        end
    end

    // Next-state logic for the FSM, datapath and result registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        bin_out_d = bin_out_q;
        ovf_d     = ovf_q;
        invalid_d = invalid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    if (in_ok) begin
                        bcd_d     = bcd_in_i;
                        bin_d     = '0;
                        cnt_d     = '0;
                        invalid_d = 1'b0;
                        state_d   = StShift;
                    end else begin
                        // Bad digit: report immediately, skip the conversion
                        invalid_d = 1'b1;
                        ovf_d     = 1'b0;
                        bin_out_d = '0;
                        state_d   = StDone;
                    end
                end
            end
            StShift: begin
                bcd_d = bcd_adj;
                bin_d = shifted[ITER-1:0];
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    bin_out_d = shifted[7:0];
                    ovf_d     = shifted[ITER-1:0] > ITER'(BIN_MAX);
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            bin_out_q <= '0;
            ovf_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            bin_out_q <= bin_out_d;
            ovf_q     <= ovf_d;
            invalid_q <= invalid_d;
        end
    end

    // All decimal weight must have drained into the binary side by the last step
    always_ff @(posedge clk) begin
        if (rst_n && state_q == StShift && last_iter) begin
            assert (bcd_adj == '0);
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign bin_out_o   = bin_out_q;
    assign ovf_o       = ovf_q;
    assign invalid_o   = invalid_q;

endmodule

// File: tb/tb_bcd_decoder_seq.sv
// Self-checking bench for bcd_decoder_seq: a transaction-level reference
// model predicts handshakes and results every cycle, plus directed checks.
module tb_bcd_decoder_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  bin_out;
    logic        ovf;
    logic        invalid;

    int n_chk  = 0;
    int n_fail = 0;

    bcd_decoder_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .bcd_in_i    (bcd_in),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .bin_out_o   (bin_out),
        .ovf_o       (ovf),
        .invalid_o   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bin;
        logic       ovf;
        logic       inv;
    } res_t;

    // Decimal meaning of the word, straight from the digit weights
    function automatic res_t ref_decode(input logic [11:0] b);
        res_t r;
        int   h, t, u, v;
        h = int'(b[11:8]);
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        if (h > 9 || t > 9 || u > 9) begin
            r.bin = 8'd0;
            r.ovf = 1'b0;
            r.inv = 1'b1;
        end else begin
            v     = h * 100 + t * 10 + u;
            r.bin = 8'(v % 256);
            r.ovf = (v > 255);
            r.inv = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [11:0] bin2bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: idle, busy for a fixed number of edges, or holding a result
    logic m_valid = 1'b0;
    int   m_wait  = 0;
    res_t m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_wait  = 0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_valid = 1'b1;
        end else if (in_valid) begin
            m_res = ref_decode(bcd_in);
            if (m_res.inv) m_valid = 1'b1;
            else m_wait = 10;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(!m_valid && m_wait == 0));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("bin_out", 32'(bin_out), 32'(m_res.bin));
                chk("ovf", 32'(ovf), 32'(m_res.ovf));
                chk("invalid", 32'(invalid), 32'(m_res.inv));
            end
        end
    end

    // Offer a word at a negedge; returns at the negedge after it was accepted
    task automatic send(input logic [11:0] b);
        int n;
        n        = 0;
        in_valid = 1'b1;
        bcd_in   = b;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        int         e;
        logic       done;
        logic [11:0] b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_bin_out", 32'(bin_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_invalid", 32'(invalid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-conversion discards the word
        out_ready = 1'b1;
        send(12'h123);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("rst_discard", 32'(out_valid), 32'd0);
        send(12'h045);
        wait_done();
        chk("after_rst_bin", 32'(bin_out), 32'h2D);
        @(negedge clk);

        // Overflow boundaries
        send(12'h999);
        wait_done();
        chk("999_bin", 32'(bin_out), 32'hE7);
        chk("999_ovf", 32'(ovf), 32'd1);
        @(negedge clk);
        send(12'h256);
        wait_done();
        chk("256_bin", 32'(bin_out), 32'h00);
        chk("256_ovf", 32'(ovf), 32'd1);
        @(negedge clk);
        send(12'h255);
        wait_done();
        chk("255_bin", 32'(bin_out), 32'hFF);
        chk("255_ovf", 32'(ovf), 32'd0);
        @(negedge clk);

        // Invalid digit: result visible right after the accepting edge
        out_ready = 1'b0;
        send(12'h1A3);
        chk("inv_latency", 32'(out_valid), 32'd1);
        chk("inv_flag", 32'(invalid), 32'd1);
        chk("inv_bin", 32'(bin_out), 32'd0);
        chk("inv_ovf", 32'(ovf), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);

        // Backpressure with a competing offer that must be ignored
        out_ready = 1'b0;
        send(12'h042);
        wait_done();
        in_valid = 1'b1;
        bcd_in   = 12'h777;
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_bin", 32'(bin_out), 32'h2A);
            chk("bp_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // Back-to-back with in_valid held high
        in_valid = 1'b1;
        bcd_in   = 12'h000;
        @(negedge clk);
        bcd_in = 12'h100;
        e      = 1;
        while (!in_ready && e < 50) begin
            @(negedge clk);
            e++;
        end
        chk("b2b_gap", 32'(e), 32'd12);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done();
        chk("b2b_bin", 32'(bin_out), 32'h64);
        @(negedge clk);

        // Exhaustive round trip through the binary-to-BCD encoding
        for (int v = 0; v < 256; v++) begin
            send(bin2bcd(v));
            wait_done();
            chk("rt_bin", 32'(bin_out), 32'(v));
        end
        @(negedge clk);

        // Random words and random consumer stalls
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 12'($urandom);
            end else begin
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9))};
            end
            send(b);
            e = 0;
            do begin
                out_ready = 1'($urandom_range(0, 1));
                done      = out_valid && out_ready;
                @(negedge clk);
                e++;
            end while (!done && e < 200);
            chk("rand_timeout", 32'(done), 32'd1);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
